// File: rtl/sd_spi_cmd_engine.sv
// sd_spi_cmd_engine: SPI-mode SD card command engine (power-up clocks, CRC7 command framing, response capture).
// Ports:
//   clk, rst_n                 system clock, asynchronous active-low reset
//   init_req                   start the power-up dummy-clock sequence (IDLE only)
//   cmd_valid/cmd_ready        command handshake; cmd_index, cmd_arg, resp_len, fast_mode latched on accept
//   resp_valid                 one-cycle completion pulse with resp_data (right-aligned) and resp_timeout
//   busy                       inverse of cmd_ready
//   sd_cclk, sd_mosi_cmd, sd_cs, sd_miso_data   SPI mode 0 card interface
module sd_spi_cmd_engine #(
   parameter int CLK_HZ        = 100000000,
   parameter int INIT_HZ       = 400000,
   parameter int FAST_HZ       = 25000000,
   parameter int TIMEOUT_BYTES = 8,
   parameter int DUMMY_CLOCKS  = 80
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        init_req,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [5:0]  cmd_index,
   input  logic [31:0] cmd_arg,
   input  logic [2:0]  resp_len,
   input  logic        fast_mode,
   output logic        resp_valid,
   output logic [39:0] resp_data,
   output logic        resp_timeout,
   output logic        busy,
   output logic        sd_cclk,
   output logic        sd_mosi_cmd,
   input  logic        sd_miso_data,
   output logic        sd_cs
);
   typedef enum logic [2:0] {IDLE, DUMMY, SEND, WAIT_RESP, RECV, TRAIL, DONE} state_t;
   localparam logic [15:0] HP_INIT = 16'(CLK_HZ / (2 * INIT_HZ));
   localparam logic [15:0] HP_FAST = 16'(CLK_HZ / (2 * FAST_HZ));
   localparam logic [15:0] N_DUMMY = 16'(DUMMY_CLOCKS);
   localparam logic [15:0] N_TMO   = 16'(TIMEOUT_BYTES * 8);
   state_t      state_q, state_d;
   logic [15:0] div_q, div_d, cnt_q, cnt_d;
   logic        cclk_q, cclk_d, fast_q, fast_d, tmo_q, tmo_d, resp_tmo_q, resp_tmo_d;
   logic [2:0]  len_q, len_d;
   logic [55:0] sh_q, sh_d;
   logic [39:0] resp_q, resp_d;
   logic        active, tick, rise, fall;

   function automatic logic [6:0] crc7(input logic [39:0] m);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = 39; i >= 0; i--) begin
         fb = m[i] ^ c[6];
         c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
      return c;
   endfunction

   // The divider only runs while a transfer is on the wire; an edge event toggles sd_cclk.
   assign active = !(state_q inside {IDLE, DONE});
   assign tick   = div_q == (fast_q ? HP_FAST : HP_INIT) - 16'd1;
   assign rise   = tick & ~cclk_q;
   assign fall   = tick & cclk_q;

   always_comb begin
      state_d    = state_q;
      div_d      = active ? (tick ? '0 : div_q + 16'd1) : '0;
      cclk_d     = active ? cclk_q ^ tick : 1'b0;
      cnt_d      = cnt_q;
      fast_d     = fast_q;
      len_d      = len_q;
      sh_d       = sh_q;
      tmo_d      = tmo_q;
      resp_d     = resp_q;
      resp_tmo_d = resp_tmo_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (init_req) begin
               state_d = DUMMY;
               fast_d  = fast_mode;
            end else if (cmd_valid) begin
               state_d = SEND;
               fast_d  = fast_mode;
               len_d   = (resp_len == 3'd0) ? 3'd1 : (resp_len > 3'd5) ? 3'd5 : resp_len;
               sh_d    = {8'hFF, 2'b01, cmd_index, cmd_arg, crc7({2'b01, cmd_index, cmd_arg}), 1'b1};
               tmo_d   = 1'b0;
            end
         end
         DUMMY: if (fall) begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == N_DUMMY - 16'd1) begin
               state_d    = DONE;
               cnt_d      = '0;
               resp_tmo_d = 1'b0;
            end
         end
         SEND: if (fall) begin
            sh_d  = {sh_q[54:0], 1'b0};
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == 16'd55) begin
               state_d = WAIT_RESP;
               cnt_d   = '0;
            end
         end
         // The shift register is reused for reception; the start bit seeds it with a single 0.
         WAIT_RESP: if (rise) begin
            cnt_d = cnt_q + 16'd1;
            if (!sd_miso_data) begin
               state_d = RECV;
               cnt_d   = 16'd1;
               sh_d    = '0;
            end else if (cnt_q == N_TMO - 16'd1) begin
               state_d = TRAIL;
               cnt_d   = '0;
               tmo_d   = 1'b1;
               sh_d    = '1;
            end
         end
         RECV: if (rise) begin
            sh_d  = {sh_q[54:0], sd_miso_data};
            cnt_d = cnt_q + 16'd1;
            if (cnt_q + 16'd1 == {10'd0, len_q, 3'b0}) begin
               state_d = TRAIL;
               cnt_d   = '0;
            end
         end
         // Entered right after a rising edge, so the pending falling edge is not a trail clock.
         TRAIL: begin
            cnt_d = cnt_q + {15'd0, rise};
            if (fall && cnt_q == 16'd8) begin
               state_d    = DONE;
               cnt_d      = '0;
               resp_d     = sh_q[39:0];
               resp_tmo_d = tmo_q;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         div_q      <= '0;
         cnt_q      <= '0;
         cclk_q     <= 1'b0;
         fast_q     <= 1'b0;
         len_q      <= 3'd1;
         sh_q       <= '0;
         tmo_q      <= 1'b0;
         resp_q     <= '0;
         resp_tmo_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         cnt_q      <= cnt_d;
         cclk_q     <= cclk_d;
         fast_q     <= fast_d;
         len_q      <= len_d;
         sh_q       <= sh_d;
         tmo_q      <= tmo_d;
         resp_q     <= resp_d;
         resp_tmo_q <= resp_tmo_d;
      end
   end

   assign cmd_ready    = state_q == IDLE;
   assign busy         = ~cmd_ready;
   assign resp_valid   = state_q == DONE;
   assign resp_data    = resp_q;
   assign resp_timeout = resp_tmo_q;
   assign sd_cclk      = cclk_q;
   assign sd_cs        = !(state_q inside {SEND, WAIT_RESP, RECV, TRAIL});
   assign sd_mosi_cmd  = (state_q == SEND) ? sh_q[55] : 1'b1;
endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// tb_sd_spi_cmd_engine: scoreboard bench with an SD card response model for sd_spi_cmd_engine.
module tb_sd_spi_cmd_engine;
   logic        clk = 1'b0, rst_n = 1'b0, init_req = 1'b0, cmd_valid = 1'b0, fast_mode = 1'b0;
   logic        sd_miso_data = 1'b1;
   logic [5:0]  cmd_index = '0;
   logic [31:0] cmd_arg = '0;
   logic [2:0]  resp_len = 3'd1;
   logic        cmd_ready, resp_valid, resp_timeout, busy, sd_cclk, sd_mosi_cmd, sd_cs;
   logic [39:0] resp_data;

   sd_spi_cmd_engine dut (
      .clk(clk), .rst_n(rst_n), .init_req(init_req), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_len(resp_len), .fast_mode(fast_mode),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_timeout(resp_timeout), .busy(busy),
      .sd_cclk(sd_cclk), .sd_mosi_cmd(sd_mosi_cmd), .sd_miso_data(sd_miso_data), .sd_cs(sd_cs)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [39:0] d;
      logic        t;
   } exp_t;

   int          errors = 0, checks = 0, n_valid = 0, hs = 0;
   int          rises = 0, dummy_pulses = 0, mosi_bad = 0, cs_falls = 0;
   int          cyc = 0, last_rise = -1, per_min = 1 << 30, per_max = 0;
   logic        mosi_bits[$];
   exp_t        sb[$];
   exp_t        got, exp_e;
   logic [39:0] exp_last = '0, exp_d;
   int          exp_l;
   bit          card_on = 1'b0;
   int          wait_bytes = 0, rsp_n = 1;
   logic [39:0] rsp_val = '0;

   // Card model: ones during the command and NCR gap, then the response MSB first.
   function automatic logic card_bit(input int k);
      int j;
      j = k - 56 - 8 * wait_bytes;
      if (!card_on || j < 0 || j >= 8 * rsp_n) return 1'b1;
      return rsp_val[8 * rsp_n - 1 - j];
   endfunction

   function automatic logic [55:0] frame_of();
      logic [55:0] f;
      f = '0;
      for (int i = 0; i < 56 && i < mosi_bits.size(); i++) f = {f[54:0], mosi_bits[i]};
      return f;
   endfunction

   function automatic int trail_ones();
      int n;
      n = 0;
      for (int i = 56; i < mosi_bits.size(); i++) n += (mosi_bits[i] === 1'b1) ? 1 : 0;
      return n;
   endfunction

   always @(posedge clk) cyc++;

   always @(posedge sd_cclk) begin
      if (last_rise >= 0) begin
         per_min = (cyc - last_rise < per_min) ? cyc - last_rise : per_min;
         per_max = (cyc - last_rise > per_max) ? cyc - last_rise : per_max;
      end
      last_rise = cyc;
      if (sd_cs) begin
         dummy_pulses++;
         if (sd_mosi_cmd !== 1'b1) mosi_bad++;
      end else begin
         mosi_bits.push_back(sd_mosi_cmd);
         rises++;
      end
   end

   always @(negedge sd_cclk) sd_miso_data = card_bit(rises);

   always @(negedge sd_cs) begin
      cs_falls++;
      rises = 0;
      mosi_bits.delete();
      sd_miso_data = card_bit(0);
   end

   // Acceptance monitor: every handshake pushes the expected completion.
   always @(negedge clk) begin
      if (rst_n && cmd_ready && (init_req || cmd_valid)) begin
         hs++;
         if (init_req) sb.push_back({exp_last, 1'b0});
         else begin
            exp_l = (resp_len == 3'd0) ? 1 : (resp_len > 3'd5) ? 5 : int'(resp_len);
            if (card_on && wait_bytes < 8) begin
               exp_d = rsp_val >> (8 * (rsp_n - exp_l));
               sb.push_back({exp_d, 1'b0});
            end else begin
               exp_d = '1;
               sb.push_back({exp_d, 1'b1});
            end
            exp_last = exp_d;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && resp_valid) begin
         n_valid++;
         checks++;
         got = {resp_data, resp_timeout};
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected: got data=%h tmo=%b, required no response", resp_data, resp_timeout);
         end else begin
            exp_e = sb.pop_front();
            if (got !== exp_e) begin
               errors++;
               $display("FAIL resp_scoreboard: got data=%h tmo=%b, required data=%h tmo=%b",
                        got.d, got.t, exp_e.d, exp_e.t);
            end
         end
      end
   end

   task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [2:0] len, input logic fast);
      @(posedge clk);
      #1;
      cmd_index = idx;
      cmd_arg   = arg;
      resp_len  = len;
      fast_mode = fast;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_index = 6'($urandom);
      cmd_arg   = $urandom;
      resp_len  = 3'($urandom);
      fast_mode = ~fast;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      int v;
      v  = n_valid;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         if (n_valid != v) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({cmd_ready, busy, resp_valid, resp_timeout, sd_cclk, sd_mosi_cmd, sd_cs} !== 7'b1000011) begin
         errors++;
         $display("FAIL reset_ctrl: got %b, required 1000011",
                  {cmd_ready, busy, resp_valid, resp_timeout, sd_cclk, sd_mosi_cmd, sd_cs});
      end
      checks++;
      if (resp_data !== 40'h0) begin
         errors++;
         $display("FAIL reset_data: got %h, required 0000000000", resp_data);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_init();
      bit ok;
      int v0;
      v0 = n_valid;
      dummy_pulses = 0; mosi_bad = 0; cs_falls = 0;
      last_rise = -1; per_min = 1 << 30; per_max = 0;
      @(posedge clk);
      #1;
      init_req = 1'b1; cmd_valid = 1'b1; fast_mode = 1'b0;
      @(posedge clk);
      #1;
      init_req = 1'b0; cmd_valid = 1'b0; fast_mode = 1'b1;
      checks++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL init_busy: got busy=%b ready=%b, required busy=1 ready=0", busy, cmd_ready);
      end
      wait_done(21000, ok);
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (!ok) begin errors++; $display("FAIL init_done: got no resp_valid, required one within 21000 cycles"); end
      checks++;
      if (dummy_pulses != 80) begin errors++; $display("FAIL init_pulses: got %0d, required 80", dummy_pulses); end
      checks++;
      if (per_min != 250 || per_max != 250) begin
         errors++;
         $display("FAIL init_period: got min=%0d max=%0d, required 250", per_min, per_max);
      end
      checks++;
      if (mosi_bad != 0 || cs_falls != 0) begin
         errors++;
         $display("FAIL init_lines: got mosi_low=%0d cs_falls=%0d, required 0 0", mosi_bad, cs_falls);
      end
      checks++;
      if (n_valid - v0 != 1) begin errors++; $display("FAIL init_valid_count: got %0d, required 1", n_valid - v0); end
   endtask

   task automatic test_cmd0();
      bit ok;
      card_on = 1'b1; wait_bytes = 2; rsp_val = 40'h01; rsp_n = 1;
      last_rise = -1; per_min = 1 << 30; per_max = 0;
      issue(6'd0, 32'h0, 3'd1, 1'b0);
      wait_done(25000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL cmd0_done: got no resp_valid, required one"); end
      checks++;
      if (frame_of() !== 56'hFF400000000095) begin
         errors++;
         $display("FAIL cmd0_frame: got %h, required ff400000000095", frame_of());
      end
      checks++;
      if (mosi_bits.size() != 88 || trail_ones() != 32) begin
         errors++;
         $display("FAIL cmd0_bits: got clocks=%0d ones=%0d, required 88 32", mosi_bits.size(), trail_ones());
      end
      checks++;
      if (per_min != 250 || per_max != 250) begin
         errors++;
         $display("FAIL cmd0_period: got min=%0d max=%0d, required 250", per_min, per_max);
      end
   endtask

   task automatic test_cmd8();
      bit ok;
      int v0, h0;
      card_on = 1'b1; wait_bytes = 1; rsp_val = 40'h01000001AA; rsp_n = 5;
      last_rise = -1; per_min = 1 << 30; per_max = 0;
      v0 = n_valid; h0 = hs;
      issue(6'd8, 32'h000001AA, 3'd5, 1'b1);
      repeat (100) @(posedge clk);
      #1;
      init_req = 1'b1; cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      init_req = 1'b0; cmd_valid = 1'b0;
      wait_done(2000, ok);
      repeat (20) @(posedge clk);
      checks++;
      if (!ok) begin errors++; $display("FAIL cmd8_done: got no resp_valid, required one"); end
      checks++;
      if (frame_of() !== 56'hFF48000001AA87) begin
         errors++;
         $display("FAIL cmd8_frame: got %h, required ff48000001aa87", frame_of());
      end
      checks++;
      if (mosi_bits.size() != 112) begin errors++; $display("FAIL cmd8_clocks: got %0d, required 112", mosi_bits.size()); end
      checks++;
      if (per_min != 4 || per_max != 4) begin
         errors++;
         $display("FAIL cmd8_period: got min=%0d max=%0d, required 4", per_min, per_max);
      end
      checks++;
      if (n_valid - v0 != 1 || hs - h0 != 1) begin
         errors++;
         $display("FAIL cmd8_ignore: got valids=%0d handshakes=%0d, required 1 1", n_valid - v0, hs - h0);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      card_on = 1'b0;
      issue(6'd0, 32'h0, 3'd1, 1'b1);
      wait_done(2000, ok);
      #1;
      checks++;
      if (!ok) begin errors++; $display("FAIL tmo_done: got no resp_valid, required one"); end
      checks++;
      if (mosi_bits.size() != 128 || trail_ones() != 72) begin
         errors++;
         $display("FAIL tmo_clocks: got clocks=%0d ones=%0d, required 128 72", mosi_bits.size(), trail_ones());
      end
      checks++;
      if (sd_cs !== 1'b1 || sd_cclk !== 1'b0) begin
         errors++;
         $display("FAIL tmo_idle_lines: got cs=%b cclk=%b, required 1 0", sd_cs, sd_cclk);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      card_on = 1'b1; wait_bytes = 1; rsp_val = 40'h01; rsp_n = 1;
      issue(6'd0, 32'h0, 3'd1, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         if (mosi_bits.size() >= 20) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL rstmid_reach: got %0d bits, required 20", mosi_bits.size()); end
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({sd_cs, sd_cclk, sd_mosi_cmd, cmd_ready, busy, resp_valid, resp_timeout} !== 7'b1011000) begin
         errors++;
         $display("FAIL rstmid_lines: got %b, required 1011000",
                  {sd_cs, sd_cclk, sd_mosi_cmd, cmd_ready, busy, resp_valid, resp_timeout});
      end
      checks++;
      if (resp_data !== 40'h0) begin errors++; $display("FAIL rstmid_data: got %h, required 0000000000", resp_data); end
      sb.delete();
      exp_last = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cmd_index = 6'd0; cmd_arg = 32'h0; resp_len = 3'd1; fast_mode = 1'b1; cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_accept: got busy=%b, required 1", busy); end
      wait_done(2000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rstmid_done: got no resp_valid, required one"); end
      checks++;
      if (frame_of() !== 56'hFF400000000095) begin
         errors++;
         $display("FAIL rstmid_frame: got %h, required ff400000000095", frame_of());
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int v0, h0;
      card_on = 1'b1; wait_bytes = 0; rsp_val = 40'h0123456789; rsp_n = 5;
      v0 = n_valid; h0 = hs;
      @(posedge clk);
      #1;
      cmd_index = 6'd17; cmd_arg = 32'h12345678; resp_len = 3'd7; fast_mode = 1'b1; cmd_valid = 1'b1;
      wait_done(2000, ok);
      checks++;
      if (!ok || hs - h0 != 1) begin
         errors++;
         $display("FAIL b2b_hold: got done=%0d handshakes=%0d, required 1 1", ok, hs - h0);
      end
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         if (hs - h0 == 2) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
      cmd_valid = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_reaccept: got %0d handshakes, required 2", hs - h0); end
      wait_done(2000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_second: got no resp_valid, required one"); end
      issue(6'd17, 32'h0, 3'd0, 1'b1);
      wait_done(2000, ok);
      repeat (20) @(posedge clk);
      checks++;
      if (!ok || n_valid - v0 != 3 || hs - h0 != 3) begin
         errors++;
         $display("FAIL b2b_counts: got valids=%0d handshakes=%0d, required 3 3", n_valid - v0, hs - h0);
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_cmd0();
      test_cmd8();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending, required 0", sb.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
